// File: rtl/world_hour_setter.sv
// Hour edit path for the world-time display: edits the hour as shown for the
// selected city and converts it back to home time as a one-cycle load.
module world_hour_setter #(
   parameter logic [4:0] OFS0      = 5'd0,
   parameter logic [4:0] OFS1      = 5'd23,
   parameter logic [4:0] OFS2      = 5'd15,
   parameter logic [4:0] OFS3      = 5'd10,
   parameter int         TIMEOUT   = 50000,
   parameter int         BLINK_DIV = 5000
) (
   input  logic       CLK,
   input  logic       RESETN,
   input  logic       SET_KEY,
   input  logic       UP_KEY,
   input  logic       DOWN_KEY,
   input  logic [2:0] W_COUNT,
   input  logic [6:0] HOUR_CUR,
   output logic       EDIT,
   output logic       BLINK,
   output logic [3:0] HOUR_E10,
   output logic [3:0] HOUR_E1,
   output logic [6:0] HOUR_LOAD,
   output logic       LOAD
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_EDIT   = 2'd1;
   localparam logic [1:0] ST_COMMIT = 2'd2;

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int BW = $clog2(BLINK_DIV + 1);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
   localparam logic [BW-1:0] BL_LAST = BW'(BLINK_DIV - 1);

   logic [1:0]    state;
   logic [4:0]    e_hour;
   logic [2:0]    city;
   logic [TW-1:0] to_cnt;
   logic [BW-1:0] blink_cnt;
   logic [2:0]    sync_a, sync_b, sync_prev, pulse;
   logic          set_p, up_p, down_p;
   logic [4:0]    hour_home, world_live, disp;

   function automatic logic [4:0] ofs_of(input logic [2:0] idx);
      case (idx)
         3'd0:    ofs_of = OFS0;
         3'd1:    ofs_of = OFS1;
         3'd2:    ofs_of = OFS2;
         3'd3:    ofs_of = OFS3;
         default: ofs_of = 5'd0;
      endcase
   endfunction

   // Inputs never exceed 47, so one conditional subtraction is enough.
   function automatic logic [4:0] mod24(input logic [5:0] v);
      logic [5:0] t;
      t = v - 6'd24;
      mod24 = (v >= 6'd24) ? t[4:0] : v[4:0];
   endfunction

   // Two-stage synchroniser plus edge detector: one pulse per press, however long held.
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         sync_a    <= 3'b000;
         sync_b    <= 3'b000;
         sync_prev <= 3'b000;
      end else begin
         sync_a    <= {SET_KEY, UP_KEY, DOWN_KEY};
         sync_b    <= sync_a;
         sync_prev <= sync_b;
      end
   end

   assign pulse  = sync_b & ~sync_prev;
   assign set_p  = pulse[2];
   assign up_p   = pulse[1];
   assign down_p = pulse[0];

   assign hour_home  = (HOUR_CUR > 7'd23) ? 5'd0 : HOUR_CUR[4:0];
   assign world_live = mod24({1'b0, hour_home} + {1'b0, ofs_of(W_COUNT)});

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         state     <= ST_IDLE;
         EDIT      <= 1'b0;
         BLINK     <= 1'b0;
         LOAD      <= 1'b0;
         HOUR_LOAD <= 7'd0;
         e_hour    <= 5'd0;
         city      <= 3'd0;
         to_cnt    <= '0;
         blink_cnt <= '0;
      end else begin
         LOAD <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (set_p) begin
                  e_hour    <= world_live;
                  city      <= W_COUNT;
                  state     <= ST_EDIT;
                  EDIT      <= 1'b1;
                  BLINK     <= 1'b1;
                  blink_cnt <= '0;
                  to_cnt    <= '0;
               end
            end
            ST_EDIT: begin
               if (blink_cnt == BL_LAST) begin
                  blink_cnt <= '0;
                  BLINK     <= ~BLINK;
               end else begin
                  blink_cnt <= blink_cnt + BW'(1);
               end
               // Leaving EDIT overrides the blink update above.
               if (set_p) begin
                  state     <= ST_COMMIT;
                  EDIT      <= 1'b0;
                  BLINK     <= 1'b0;
                  blink_cnt <= '0;
                  LOAD      <= 1'b1;
                  HOUR_LOAD <= {2'b00, mod24({1'b0, e_hour} + 6'd24 - {1'b0, ofs_of(city)})};
               end else if (up_p || down_p) begin
                  to_cnt <= '0;
                  if (up_p && !down_p)
                     e_hour <= (e_hour == 5'd23) ? 5'd0 : e_hour + 5'd1;
                  else if (down_p && !up_p)
                     e_hour <= (e_hour == 5'd0) ? 5'd23 : e_hour - 5'd1;
               end else if (to_cnt == TO_LAST) begin
                  state     <= ST_IDLE;
                  EDIT      <= 1'b0;
                  BLINK     <= 1'b0;
                  blink_cnt <= '0;
               end else begin
                  to_cnt <= to_cnt + TW'(1);
               end
            end
            ST_COMMIT: state <= ST_IDLE;
            default:   state <= ST_IDLE;
         endcase
      end
   end

   assign disp = EDIT ? e_hour : world_live;

   always_comb begin
      logic [4:0] diff;
      HOUR_E10 = 4'd0;
      diff     = disp;
      if (disp >= 5'd20) begin
         HOUR_E10 = 4'd2;
         diff     = disp - 5'd20;
      end else if (disp >= 5'd10) begin
         HOUR_E10 = 4'd1;
         diff     = disp - 5'd10;
      end
      HOUR_E1 = diff[3:0];
   end

endmodule

// File: tb/tb_world_hour_setter.sv
// Directed bench for world_hour_setter: a long-timeout instance for editing and
// display, a short-timeout instance for the abandon and reset-abort cases.
module tb_world_hour_setter;

   localparam int K_SET  = 4;
   localparam int K_UP   = 2;
   localparam int K_DOWN = 1;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       set_key = 1'b0, up_key = 1'b0, down_key = 1'b0;
   logic [2:0] w_count = 3'd0;
   logic [6:0] hour_cur = 7'd0;

   logic       edit_a, blink_a, load_a, edit_b, blink_b, load_b;
   logic [3:0] e10_a, e1_a, e10_b, e1_b;
   logic [6:0] hour_load_a, hour_load_b;

   int tests_run = 0;
   int tests_failed = 0;
   int load_cnt_a = 0;
   int load_cnt_b = 0;
   int ofs_tb[5] = '{0, 23, 15, 10, 0};

   always #5 clk = ~clk;

   world_hour_setter #(.TIMEOUT(200), .BLINK_DIV(8)) dut_a (
      .CLK(clk), .RESETN(rst_n), .SET_KEY(set_key), .UP_KEY(up_key), .DOWN_KEY(down_key),
      .W_COUNT(w_count), .HOUR_CUR(hour_cur), .EDIT(edit_a), .BLINK(blink_a),
      .HOUR_E10(e10_a), .HOUR_E1(e1_a), .HOUR_LOAD(hour_load_a), .LOAD(load_a));

   world_hour_setter #(.TIMEOUT(16), .BLINK_DIV(4)) dut_b (
      .CLK(clk), .RESETN(rst_n), .SET_KEY(set_key), .UP_KEY(up_key), .DOWN_KEY(down_key),
      .W_COUNT(w_count), .HOUR_CUR(hour_cur), .EDIT(edit_b), .BLINK(blink_b),
      .HOUR_E10(e10_b), .HOUR_E1(e1_b), .HOUR_LOAD(hour_load_b), .LOAD(load_b));

   always @(negedge clk) begin
      if (load_a) load_cnt_a++;
      if (load_b) load_cnt_b++;
   end

   task automatic checkOutput(input string tag, input int obs, input int exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input int mask, input int hold);
      set_key  = mask[2];
      up_key   = mask[1];
      down_key = mask[0];
      repeat (hold) @(negedge clk);
      set_key  = 1'b0;
      up_key   = 1'b0;
      down_key = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      int base;
      int cnt;
      int v;

      // Reset state
      repeat (2) @(negedge clk);
      checkOutput("rst_edit", edit_a, 0);
      checkOutput("rst_blink", blink_a, 0);
      checkOutput("rst_load", load_a, 0);
      checkOutput("rst_hour_load", hour_load_a, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Test 1: home city, 09 -> 12
      do_reset();
      w_count = 3'd0; hour_cur = 7'd9;
      base = load_cnt_a;
      applyStimulus(K_SET, 1);
      checkOutput("t1_edit", edit_a, 1);
      checkOutput("t1_disp_entry", {e10_a, e1_a}, 8'h09);
      repeat (3) applyStimulus(K_UP, 1);
      checkOutput("t1_disp_up3", {e10_a, e1_a}, 8'h12);
      checkOutput("t1_no_early_load", load_cnt_a - base, 0);
      applyStimulus(K_SET, 1);
      checkOutput("t1_load_once", load_cnt_a - base, 1);
      checkOutput("t1_hour_load", hour_load_a, 12);
      checkOutput("t1_edit_off", edit_a, 0);

      // Test 2: city 3, 20 -> 06, down through zero to 23, home 13
      do_reset();
      w_count = 3'd3; hour_cur = 7'd20;
      applyStimulus(K_SET, 1);
      checkOutput("t2_disp_entry", {e10_a, e1_a}, 8'h06);
      repeat (7) applyStimulus(K_DOWN, 1);
      checkOutput("t2_disp_down7", {e10_a, e1_a}, 8'h23);
      base = load_cnt_a;
      applyStimulus(K_SET, 1);
      checkOutput("t2_load_once", load_cnt_a - base, 1);
      checkOutput("t2_hour_load", hour_load_a, 13);

      // Test 3: city 2, wrap 23 -> 00, home 9
      do_reset();
      w_count = 3'd2; hour_cur = 7'd8;
      applyStimulus(K_SET, 1);
      checkOutput("t3_disp_entry", {e10_a, e1_a}, 8'h23);
      applyStimulus(K_UP, 1);
      checkOutput("t3_disp_wrap", {e10_a, e1_a}, 8'h00);
      applyStimulus(K_SET, 1);
      checkOutput("t3_hour_load", hour_load_a, 9);

      // Test 4: blink, simultaneous keys, held key, latched city
      do_reset();
      w_count = 3'd1; hour_cur = 7'd5;
      set_key = 1'b1;
      cnt = 0;
      while (!edit_a && cnt < 10) begin
         @(negedge clk);
         cnt++;
      end
      checkOutput("t4_edit_entry", edit_a, 1);
      checkOutput("t4_blink_start", blink_a, 1);
      repeat (7) @(negedge clk);
      checkOutput("t4_blink_hold", blink_a, 1);
      @(negedge clk);
      checkOutput("t4_blink_toggle", blink_a, 0);
      set_key = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("t4_disp_entry", {e10_a, e1_a}, 8'h04);
      applyStimulus(K_UP | K_DOWN, 1);
      checkOutput("t4_updown", {e10_a, e1_a}, 8'h04);
      applyStimulus(K_UP, 100);
      checkOutput("t4_held_up", {e10_a, e1_a}, 8'h05);
      w_count = 3'd3;
      @(negedge clk);
      checkOutput("t4_city_latched_disp", {e10_a, e1_a}, 8'h05);
      checkOutput("t4_still_edit", edit_a, 1);
      applyStimulus(K_SET, 1);
      checkOutput("t4_hour_load", hour_load_a, 6);

      // Test 5: timeout with no keys, then reset abort mid-edit
      do_reset();
      w_count = 3'd0; hour_cur = 7'd9;
      base = load_cnt_b;
      set_key = 1'b1;
      cnt = 0;
      while (!edit_b && cnt < 10) begin
         @(negedge clk);
         cnt++;
      end
      checkOutput("t5_edit_entry", edit_b, 1);
      set_key = 1'b0;
      cnt = 1;
      while (edit_b && cnt < 100) begin
         @(negedge clk);
         if (edit_b) cnt++;
      end
      checkOutput("t5_edit_cycles", cnt, 16);
      checkOutput("t5_no_load", load_cnt_b - base, 0);
      checkOutput("t5_hour_load_kept", hour_load_b, 0);
      applyStimulus(K_SET, 1);
      checkOutput("t5_reenter", edit_b, 1);
      applyStimulus(K_UP, 1);
      hour_cur = 7'd0;
      #3 rst_n = 1'b0;
      #1;
      checkOutput("t5_abort_edit", edit_b, 0);
      checkOutput("t5_abort_blink", blink_b, 0);
      checkOutput("t5_abort_load", load_b, 0);
      checkOutput("t5_abort_hour_load", hour_load_b, 0);
      checkOutput("t5_abort_disp", {e10_b, e1_b}, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      checkOutput("t5_abort_no_load", load_cnt_b - base, 0);

      // Test 6: idle sweep of live world hour
      do_reset();
      for (int w = 0; w < 5; w++) begin
         for (int h = 0; h < 24; h++) begin
            w_count  = 3'(w);
            hour_cur = 7'(h);
            #1;
            v = (h + ofs_tb[w]) % 24;
            checkOutput($sformatf("t6_w%0d_h%0d", w, h), {e10_a, e1_a}, ((v / 10) << 4) | (v % 10));
         end
      end
      w_count = 3'd1; hour_cur = 7'd30;
      #1;
      checkOutput("t6_hour_over_23", {e10_a, e1_a}, 8'h23);
      w_count = 3'd2; hour_cur = 7'd127;
      #1;
      checkOutput("t6_hour_127", {e10_a, e1_a}, 8'h15);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
